// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle.
// Operands come in on a valid/ready handshake and the result goes out on a second one.
// Optional feature macro: MDU_EARLY_OUT_EN. When it is defined, the unit finishes in a
// single cycle on divide-by-zero, on signed overflow, and on any zero operand.
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_w_r, is_div_r, is_rem_r, q_neg_r, r_neg_r, div_zero_r;
    // x: multiplicand / divisor magnitude
    // y: multiplier / dividend-then-quotient
    // z: accumulator / partial remainder
    logic [XLEN-1:0]   x_r, y_r, z_r;

    // Decode of the incoming request
    logic              op_legal_s, in_w_s, in_div_s, in_rem_s, in_sgn_s;
    logic              neg_a_s, neg_b_s;
    logic [XLEN-1:0]   a_ext_s, b_ext_s, mag_a_s, mag_b_s;

    // One iteration step and the final result formatting
    logic [XLEN:0]     rs_s;
    logic              ge_s, last_s;
    logic [XLEN-1:0]   x_nx_s, y_nx_s, z_nx_s, quo_s, remv_s, fin_s;

    // Sign-extend the low half to the full width
    function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
        return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    // W ops return their 32-bit result sign-extended; full-width ops return it unchanged
    function automatic logic [XLEN-1:0] fmt_res(input logic w, input logic [XLEN-1:0] v);
        return w ? sext_half(v) : v;
    endfunction

    // Classify the op and prepare the extended operands and their magnitudes
    always_comb begin
        op_legal_s = (op <= 4'd9);
        in_w_s     = (op == 4'd1) || (op >= 4'd6);
        in_div_s   = (op >= 4'd2);
        in_rem_s   = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
        in_sgn_s   = (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd4) ||
                     (op == 4'd6) || (op == 4'd8);
        if (in_w_s) begin
            a_ext_s = in_sgn_s ? sext_half(a) : {{HALF{1'b0}}, a[HALF-1:0]};
            b_ext_s = in_sgn_s ? sext_half(b) : {{HALF{1'b0}}, b[HALF-1:0]};
        end else begin
            a_ext_s = a;
            b_ext_s = b;
        end
        neg_a_s = in_sgn_s & a_ext_s[XLEN-1];
        neg_b_s = in_sgn_s & b_ext_s[XLEN-1];
        mag_a_s = neg_a_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
        mag_b_s = neg_b_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;
    end

    // Compute one multiply or divide step, plus the result it would finish with
    always_comb begin
        rs_s = {z_r, y_r[XLEN-1]};
        ge_s = (rs_s >= {1'b0, x_r});
        if (is_div_r) begin
            x_nx_s = x_r;
            y_nx_s = {y_r[XLEN-2:0], ge_s};
            z_nx_s = ge_s ? (rs_s[XLEN-1:0] - x_r) : rs_s[XLEN-1:0];
        end else begin
            x_nx_s = x_r << 1;
            y_nx_s = y_r >> 1;
            z_nx_s = z_r + (y_r[0] ? x_r : {XLEN{1'b0}});
        end
        // A zero divisor always yields an all-ones quotient, so it must skip the sign fixup
        if (div_zero_r) begin
            quo_s = {XLEN{1'b1}};
        end else begin
            quo_s = q_neg_r ? ({XLEN{1'b0}} - y_nx_s) : y_nx_s;
        end
        remv_s = r_neg_r ? ({XLEN{1'b0}} - z_nx_s) : z_nx_s;
        if (!is_div_r) begin
            fin_s = fmt_res(is_w_r, z_nx_s);
        end else if (is_rem_r) begin
            fin_s = fmt_res(is_w_r, remv_s);
        end else begin
            fin_s = fmt_res(is_w_r, quo_s);
        end
        last_s = (cnt_r == (is_w_r ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1)));
    end

`ifdef MDU_EARLY_OUT_EN
    logic              ovf_s, early_hit_s;
    logic [XLEN-1:0]   min_val_s, early_c_s;

    // Detect requests whose result is known without iterating
    always_comb begin
        min_val_s = in_w_s ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                           : {1'b1, {(XLEN - 1){1'b0}}};
        ovf_s       = in_div_s && in_sgn_s && (a_ext_s == min_val_s) && (b_ext_s == {XLEN{1'b1}});
        early_hit_s = (a_ext_s == {XLEN{1'b0}}) || (b_ext_s == {XLEN{1'b0}}) || ovf_s;
        if (!in_div_s) begin
            early_c_s = {XLEN{1'b0}};
        end else if (b_ext_s == {XLEN{1'b0}}) begin
            early_c_s = in_rem_s ? fmt_res(in_w_s, a_ext_s) : {XLEN{1'b1}};
        end else if (ovf_s) begin
            early_c_s = in_rem_s ? {XLEN{1'b0}} : fmt_res(in_w_s, a_ext_s);
        end else begin
            early_c_s = {XLEN{1'b0}};
        end
    end
`endif

    // Control FSM and datapath registers; flush overrides every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            c          <= {XLEN{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            is_w_r     <= 1'b0;
            is_div_r   <= 1'b0;
            is_rem_r   <= 1'b0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            x_r        <= {XLEN{1'b0}};
            y_r        <= {XLEN{1'b0}};
            z_r        <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        is_w_r     <= in_w_s;
                        is_div_r   <= in_div_s;
                        is_rem_r   <= in_rem_s;
                        q_neg_r    <= neg_a_s ^ neg_b_s;
                        r_neg_r    <= neg_a_s;
                        div_zero_r <= (b_ext_s == {XLEN{1'b0}});
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready   <= 1'b0;
                        if (!op_legal_s) begin
                            state_r   <= DONE;
                            out_valid <= 1'b1;
                            c         <= {XLEN{1'b0}};
`ifdef MDU_EARLY_OUT_EN
                        end else if (early_hit_s) begin
                            state_r   <= DONE;
                            out_valid <= 1'b1;
                            c         <= early_c_s;
`endif
                        end else begin
                            state_r <= BUSY;
                            x_r     <= in_div_s ? mag_b_s : a_ext_s;
                            // W division starts at bit 31, so park the dividend in the top half
                            if (in_div_s) begin
                                y_r <= in_w_s ? {mag_a_s[HALF-1:0], {HALF{1'b0}}} : mag_a_s;
                            end else begin
                                y_r <= b_ext_s;
                            end
                            z_r     <= {XLEN{1'b0}};
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    x_r <= x_nx_s;
                    y_r <= y_nx_s;
                    z_r <= z_nx_s;
                    if (last_s) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        c         <= fin_s;
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    cnt_r     <= {CNT_W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter against an arithmetic model.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] c;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Expected result computed directly with language arithmetic
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        longint      sa, sb;
        int          wa, wb;
        int unsigned ua, ub;
        logic [31:0] r32;
        sa = x; sb = y; wa = x[31:0]; wb = y[31:0]; ua = x[31:0]; ub = y[31:0];
        case (o)
            4'd0: return x * y;
            4'd1: begin r32 = ua * ub; return sx32(r32); end
            4'd2: begin
                if (y == 64'd0) return '1;
                if (x == 64'h8000_0000_0000_0000 && y == '1) return x;
                return sa / sb;
            end
            4'd3: begin
                if (y == 64'd0) return '1;
                return x / y;
            end
            4'd4: begin
                if (y == 64'd0) return x;
                if (x == 64'h8000_0000_0000_0000 && y == '1) return 64'd0;
                return sa % sb;
            end
            4'd5: begin
                if (y == 64'd0) return x;
                return x % y;
            end
            4'd6: begin
                if (wb == 0) return '1;
                if (wa == 32'sh8000_0000 && wb == -1) return sx32(x[31:0]);
                r32 = wa / wb; return sx32(r32);
            end
            4'd7: begin
                if (ub == 32'd0) return '1;
                r32 = ua / ub; return sx32(r32);
            end
            4'd8: begin
                if (wb == 0) return sx32(x[31:0]);
                if (wa == 32'sh8000_0000 && wb == -1) return 64'd0;
                r32 = wa % wb; return sx32(r32);
            end
            4'd9: begin
                if (ub == 32'd0) return sx32(x[31:0]);
                r32 = ua % ub; return sx32(r32);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Expected cycles from the accept cycle to the first out_valid cycle
    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        bit w;
        w = (o == 4'd1) || (o >= 4'd6);
        if (o > 4'd9) return 1;
`ifdef MDU_EARLY_OUT_EN
        begin
            bit          sg;
            logic [63:0] ea, eb;
            sg = (o == 4'd0) || (o == 4'd1) || (o == 4'd2) || (o == 4'd4) || (o == 4'd6) || (o == 4'd8);
            ea = w ? (sg ? sx32(x[31:0]) : {32'd0, x[31:0]}) : x;
            eb = w ? (sg ? sx32(y[31:0]) : {32'd0, y[31:0]}) : y;
            if (ea == 64'd0 || eb == 64'd0) return 1;
            if (o >= 4'd2 && sg && eb == '1 &&
                ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
        end
`endif
        return w ? 33 : 65;
    endfunction

    // After the accept edge: measure latency, check result, then drain
    task automatic finish_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat(o, x, y)));
        check($sformatf("result op%0d a=%h b=%h", o, x, y), c, model(o, x, y));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        check("in_ready before issue", {63'd0, in_ready}, 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish_op(o, x, y);
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int seen;
        #1 reset = 1'b1;
        #20;
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset c", c, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        run_op(4'd0, 64'd7, -64'sd3);
        run_op(4'd6, 64'h0000_0000_8000_0000, '1);
        run_op(4'd8, 64'h0000_0000_8000_0000, '1);
        run_op(4'd3, 64'd100, 64'd0);
        run_op(4'd4, -64'sd7, 64'd0);
        run_op(4'd4, -64'sd7, 64'd2);
        run_op(4'd2, -64'sd7, 64'd2);
        run_op(4'd7, 64'h0000_0000_FFFF_FFFF, 64'd1);
        run_op(4'd2, 64'h8000_0000_0000_0000, '1);
        run_op(4'd3, '1, '1);
        run_op(4'd12, 64'd5, 64'd6);

        // Random traffic
        for (int i = 0; i < 50; i++) begin
            run_op(4'($urandom_range(0, 11)), rnd_opnd(), rnd_opnd());
        end

        // Hold result in DONE for 5 cycles
        op = 4'd0; a = 64'd5; b = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        check("stall valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall hold valid", {63'd0, out_valid}, 64'd1);
            check("stall hold c", c, 64'd45);
        end

        // Handshake out and new request in the same cycle: accept only on the next one
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd3; a = 64'd1000; b = 64'd7;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b in_ready", {63'd0, in_ready}, 64'd1);
        check("b2b out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish_op(4'd3, 64'd1000, 64'd7);

        // Flush during a divide
        op = 4'd2; a = -64'sd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", {63'd0, in_ready}, 64'd1);
        check("flush out_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);
        run_op(4'd0, 64'd3, 64'd4);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 64'd2; b = 64'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush idle not accepted", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("flush idle no busy", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of BUSY
        op = 4'd2; a = 64'd12345; b = 64'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset in_ready", {63'd0, in_ready}, 64'd1);
        check("midreset c", c, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(4'd5, 64'd12345, 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
